// File: rtl/yags_direction_cache_if.sv
// Fetch lookup / EX resolve bundle for the YAGS direction caches.
// Latency: none (wires only).
// Backpressure: none; every EX presentation is consumed.
// Ports: fetch side (PC, branch), EX side (branch_signal, actual_prediction,
//        PC_from_branch_comp, GHR_EX, PHT_prediction_EX), results (GHR,
//        Taken/Not_Taken hit + prediction). master drives, slave is the cache.
interface yags_direction_cache_if #(
  parameter int GHR_size = 10,
  parameter int PC_size  = 10
);
  logic [PC_size-1:0]  PC;
  logic                branch;
  logic                branch_signal;
  logic                actual_prediction;
  logic [PC_size-1:0]  PC_from_branch_comp;
  logic [GHR_size-1:0] GHR_EX;
  logic                PHT_prediction_EX;
  logic [GHR_size-1:0] GHR;
  logic                Taken_Arr_hit;
  logic                Taken_Arr_prediction;
  logic                Not_Taken_Arr_hit;
  logic                Not_Taken_Arr_prediction;

  modport master (
    output PC, branch, branch_signal, actual_prediction,
           PC_from_branch_comp, GHR_EX, PHT_prediction_EX,
    input  GHR, Taken_Arr_hit, Taken_Arr_prediction,
           Not_Taken_Arr_hit, Not_Taken_Arr_prediction
  );

  modport slave (
    input  PC, branch, branch_signal, actual_prediction,
           PC_from_branch_comp, GHR_EX, PHT_prediction_EX,
    output GHR, Taken_Arr_hit, Taken_Arr_prediction,
           Not_Taken_Arr_hit, Not_Taken_Arr_prediction
  );
endinterface

// File: rtl/yags_direction_cache.sv
// YAGS taken/not-taken exception caches plus global history register.
// Latency: lookup combinational; GHR +1 edge; array write +2 edges (capture, apply).
// Backpressure: none; one EX update accepted per cycle, capture overwritten each cycle.
// Ports: clk, rst (async active-high), bus (slave modport of yags_direction_cache_if).
// Option: define YAGS_UPDATE_BYPASS_EN to forward the pending write into the
//         same-cycle lookup of the cache/index it targets.
module yags_direction_cache #(
  parameter int GHR_size = 10,
  parameter int PC_size  = 10,
  parameter int TAG_size = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  yags_direction_cache_if.slave bus
);
  localparam int N = 1 << GHR_size;

  // Valid bits carry reset; tag/counter storage does not need it since
  // nothing reads them without a valid bit set.
  logic [N-1:0]        t_vld, nt_vld;
  logic [TAG_size-1:0] t_tag  [N];
  logic [TAG_size-1:0] nt_tag [N];
  logic [1:0]          t_ctr  [N];
  logic [1:0]          nt_ctr [N];

  logic [GHR_size-1:0] ghr_q;

  // One-entry update capture register
  logic                upd_valid;
  logic [GHR_size-1:0] uidx;
  logic [TAG_size-1:0] utag;
  logic                uout;
  logic                usel_nt;  // also the choice bit the branch was fetched with

  // Apply stage: read selected cache, decide write
  logic                rd_vld;
  logic [TAG_size-1:0] rd_tag;
  logic [1:0]          rd_ctr;
  logic                upd_hit;
  logic                wr_en;
  logic [1:0]          wr_ctr;
  logic                t_we, nt_we;

  always_comb begin
    rd_vld  = usel_nt ? nt_vld[uidx] : t_vld[uidx];
    rd_tag  = usel_nt ? nt_tag[uidx] : t_tag[uidx];
    rd_ctr  = usel_nt ? nt_ctr[uidx] : t_ctr[uidx];
    upd_hit = rd_vld && (rd_tag == utag);
    // On a miss, only allocate when the choice PHT got this branch wrong.
    wr_en   = upd_valid && (upd_hit || (uout != usel_nt));
    if (upd_hit) begin
      if (uout) wr_ctr = (rd_ctr == 2'd3) ? 2'd3 : rd_ctr + 2'd1;
      else      wr_ctr = (rd_ctr == 2'd0) ? 2'd0 : rd_ctr - 2'd1;
    end else begin
      wr_ctr = uout ? 2'd2 : 2'd1;
    end
    t_we  = wr_en && !usel_nt;
    nt_we = wr_en &&  usel_nt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q     <= '0;
      upd_valid <= 1'b0;
      uidx      <= '0;
      utag      <= '0;
      uout      <= 1'b0;
      usel_nt   <= 1'b0;
      t_vld     <= '0;
      nt_vld    <= '0;
    end else begin
      upd_valid <= bus.branch_signal;
      if (bus.branch_signal) begin
        ghr_q   <= {ghr_q[GHR_size-2:0], bus.actual_prediction};
        uidx    <= bus.PC_from_branch_comp[GHR_size-1:0] ^ bus.GHR_EX;
        utag    <= bus.PC_from_branch_comp[TAG_size-1:0];
        uout    <= bus.actual_prediction;
        usel_nt <= bus.PHT_prediction_EX;
      end
      if (t_we)  t_vld[uidx]  <= 1'b1;
      if (nt_we) nt_vld[uidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (t_we) begin
      t_tag[uidx] <= utag;
      t_ctr[uidx] <= wr_ctr;
    end
    if (nt_we) begin
      nt_tag[uidx] <= utag;
      nt_ctr[uidx] <= wr_ctr;
    end
  end

  // Fetch lookup
  logic [GHR_size-1:0] fidx;
  logic [TAG_size-1:0] ftag;
  logic                t_e_vld, nt_e_vld;
  logic [TAG_size-1:0] t_e_tag, nt_e_tag;
  logic [1:0]          t_e_ctr, nt_e_ctr;

  assign fidx = bus.PC[GHR_size-1:0] ^ ghr_q;
  assign ftag = bus.PC[TAG_size-1:0];

`ifdef YAGS_UPDATE_BYPASS_EN
  logic t_byp, nt_byp;
  assign t_byp    = t_we  && (uidx == fidx);
  assign nt_byp   = nt_we && (uidx == fidx);
  assign t_e_vld  = t_byp  ? 1'b1   : t_vld[fidx];
  assign t_e_tag  = t_byp  ? utag   : t_tag[fidx];
  assign t_e_ctr  = t_byp  ? wr_ctr : t_ctr[fidx];
  assign nt_e_vld = nt_byp ? 1'b1   : nt_vld[fidx];
  assign nt_e_tag = nt_byp ? utag   : nt_tag[fidx];
  assign nt_e_ctr = nt_byp ? wr_ctr : nt_ctr[fidx];
`else
  assign t_e_vld  = t_vld[fidx];
  assign t_e_tag  = t_tag[fidx];
  assign t_e_ctr  = t_ctr[fidx];
  assign nt_e_vld = nt_vld[fidx];
  assign nt_e_tag = nt_tag[fidx];
  assign nt_e_ctr = nt_ctr[fidx];
`endif

  logic t_hit, nt_hit;
  assign t_hit  = bus.branch && t_e_vld  && (t_e_tag  == ftag);
  assign nt_hit = bus.branch && nt_e_vld && (nt_e_tag == ftag);

  // Prediction is qualified by hit so a stale or never-written counter
  // cannot leak out; the choice stage ignores it on a miss anyway.
  assign bus.GHR                      = ghr_q;
  assign bus.Taken_Arr_hit            = t_hit;
  assign bus.Taken_Arr_prediction     = t_hit && t_e_ctr[1];
  assign bus.Not_Taken_Arr_hit        = nt_hit;
  assign bus.Not_Taken_Arr_prediction = nt_hit && nt_e_ctr[1];
endmodule

// File: tb/tb_yags_direction_cache.sv
// Bench for yags_direction_cache: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the two caches.
// Latency/backpressure: n/a (bench).
module tb_yags_direction_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;

  yags_direction_cache_if bus ();
  yags_direction_cache dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cache 0 = taken cache, cache 1 = not-taken cache
  bit       m_vld [2][1024];
  bit [5:0] m_tag [2][1024];
  int       m_ctr [2][1024];
  bit [9:0] m_ghr;
  // pending resolved branch, applied on the edge after it was seen
  bit       p_vld;
  int       p_idx;
  bit [5:0] p_tag;
  bit       p_out;
  int       p_sel;
  // inputs presented this cycle
  bit [9:0] c_pc, c_pcx, c_gex;
  bit       c_br, c_bs, c_act, c_pht;

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 1024; i++) m_vld[c][i] = 1'b0;
    m_ghr = '0;
    p_vld = 1'b0;
  endtask

  // What the pending branch does to its cache entry (1 = entry gets written).
  function automatic bit pend_write(output int nctr);
    bit hit;
    nctr = 0;
    if (!p_vld) return 1'b0;
    hit = m_vld[p_sel][p_idx] && (m_tag[p_sel][p_idx] == p_tag);
    if (hit) begin
      nctr = p_out ? m_ctr[p_sel][p_idx] + 1 : m_ctr[p_sel][p_idx] - 1;
      if (nctr > 3) nctr = 3;
      if (nctr < 0) nctr = 0;
      return 1'b1;
    end
    // choice bit equals p_sel; allocate only when the outcome disagreed with it
    if (int'(p_out) != p_sel) begin
      nctr = p_out ? 2 : 1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_lookup(input int c, output bit hit, output bit pred);
    int idx;
    bit v;
    bit [5:0] t;
    int ct;
    idx = int'(c_pc ^ m_ghr);
    v  = m_vld[c][idx];
    t  = m_tag[c][idx];
    ct = m_ctr[c][idx];
`ifdef YAGS_UPDATE_BYPASS_EN
    begin
      int nc;
      if (p_vld && p_sel == c && p_idx == idx && pend_write(nc)) begin
        v = 1'b1; t = p_tag; ct = nc;
      end
    end
`endif
    hit  = c_br && v && (t == c_pc[5:0]);
    pred = hit && (ct >= 2);
  endtask

  task automatic model_edge();
    int nc;
    if (pend_write(nc)) begin
      m_vld[p_sel][p_idx] = 1'b1;
      m_tag[p_sel][p_idx] = p_tag;
      m_ctr[p_sel][p_idx] = nc;
    end
    p_vld = c_bs;
    if (c_bs) begin
      p_idx = int'(c_pcx ^ c_gex);
      p_tag = c_pcx[5:0];
      p_out = c_act;
      p_sel = c_pht ? 1 : 0;
      m_ghr = {m_ghr[8:0], c_act};
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge: drive, sample at the falling edge.
  task automatic drive_and_sample(input bit [9:0] pc, input bit br, input bit bs, input bit act,
                                  input bit [9:0] pcx, input bit [9:0] gex, input bit pht);
    bit th, tp, nh, np;
    c_pc = pc; c_br = br; c_bs = bs; c_act = act; c_pcx = pcx; c_gex = gex; c_pht = pht;
    bus.PC = pc; bus.branch = br; bus.branch_signal = bs; bus.actual_prediction = act;
    bus.PC_from_branch_comp = pcx; bus.GHR_EX = gex; bus.PHT_prediction_EX = pht;
    @(negedge clk);
    model_lookup(0, th, tp);
    model_lookup(1, nh, np);
    check_eq("m_ghr",    32'(bus.GHR), 32'(m_ghr));
    check_eq("m_t_hit",  32'(bus.Taken_Arr_hit), 32'(th));
    check_eq("m_t_pred", 32'(bus.Taken_Arr_prediction), 32'(tp));
    check_eq("m_n_hit",  32'(bus.Not_Taken_Arr_hit), 32'(nh));
    check_eq("m_n_pred", 32'(bus.Not_Taken_Arr_prediction), 32'(np));
  endtask

  task automatic finish_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input bit [9:0] pc, input bit br, input bit bs, input bit act,
                     input bit [9:0] pcx, input bit [9:0] gex, input bit pht);
    drive_and_sample(pc, br, bs, act, pcx, gex, pht);
    finish_edge();
  endtask

  // Fetch-only probe; leaves the bench at the falling edge for explicit checks.
  task automatic probe(input bit [9:0] pc);
    drive_and_sample(pc, 1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 1'b0);
  endtask

  // Shift a known value into the GHR with branches whose outcome matches
  // their choice bit, aimed at an index nothing else uses (no cache writes).
  task automatic set_ghr(input bit [9:0] v);
    for (int i = 9; i >= 0; i--)
      cyc(10'h0, 1'b0, 1'b1, v[i], 10'h200, 10'h0, v[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive_and_sample(10'h0A5, 1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 1'b0);
    rst = 1'b0;
    finish_edge();
  endtask

  bit [9:0] pool [16];
  bit [9:0] tgt;

  initial begin
    bus.PC = '0; bus.branch = 1'b0; bus.branch_signal = 1'b0; bus.actual_prediction = 1'b0;
    bus.PC_from_branch_comp = '0; bus.GHR_EX = '0; bus.PHT_prediction_EX = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state seen from fetch
    probe(10'h0A5);
    check_eq("rst_ghr",    32'(bus.GHR), 32'h0);
    check_eq("rst_t_hit",  32'(bus.Taken_Arr_hit), 32'h0);
    check_eq("rst_t_pred", 32'(bus.Taken_Arr_prediction), 32'h0);
    check_eq("rst_n_hit",  32'(bus.Not_Taken_Arr_hit), 32'h0);
    check_eq("rst_n_pred", 32'(bus.Not_Taken_Arr_prediction), 32'h0);
    finish_edge();

    // Three taken EX branches -> GHR = 7
    for (int i = 0; i < 3; i++) cyc(10'h0, 1'b0, 1'b1, 1'b1, 10'h200, 10'h0, 1'b1);
    probe(10'h0);
    check_eq("ghr_shift", 32'(bus.GHR), 32'h007);
    finish_edge();

    // Allocation into the taken cache on a wrong choice
    do_reset();
    cyc(10'h0, 1'b0, 1'b1, 1'b1, 10'h013, 10'h001, 1'b0);
    cyc(10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 1'b0);
    probe(10'h013);
    check_eq("alloc_t_hit",  32'(bus.Taken_Arr_hit), 32'h1);
    check_eq("alloc_t_pred", 32'(bus.Taken_Arr_prediction), 32'h1);
    check_eq("alloc_n_hit",  32'(bus.Not_Taken_Arr_hit), 32'h0);
    finish_edge();

    // Not-taken training down to saturation at 0
    for (int k = 0; k < 3; k++) begin
      cyc(10'h0, 1'b0, 1'b1, 1'b0, 10'h013, 10'h001, 1'b0);
      set_ghr(10'h001);
      probe(10'h013);
      check_eq("dec_t_hit",  32'(bus.Taken_Arr_hit), 32'h1);
      check_eq("dec_t_pred", 32'(bus.Taken_Arr_prediction), 32'h0);
      finish_edge();
    end
    // One taken from a saturated 0 lands at 1, still predicting not-taken
    cyc(10'h0, 1'b0, 1'b1, 1'b1, 10'h013, 10'h001, 1'b0);
    set_ghr(10'h001);
    probe(10'h013);
    check_eq("sat_t_pred", 32'(bus.Taken_Arr_prediction), 32'h0);
    finish_edge();
    // Second taken: 1 -> 2
    cyc(10'h0, 1'b0, 1'b1, 1'b1, 10'h013, 10'h001, 1'b0);
    set_ghr(10'h001);
    probe(10'h013);
    check_eq("inc_t_pred", 32'(bus.Taken_Arr_prediction), 32'h1);
    finish_edge();

    // Choice correct on a miss: no allocation in the not-taken cache
    cyc(10'h0, 1'b0, 1'b1, 1'b1, 10'h055, 10'h000, 1'b1);
    set_ghr(10'h000);
    probe(10'h055);
    check_eq("noalloc_n_hit", 32'(bus.Not_Taken_Arr_hit), 32'h0);
    finish_edge();
    // Choice wrong: allocate not-taken cache with counter 1
    cyc(10'h0, 1'b0, 1'b1, 1'b0, 10'h055, 10'h000, 1'b1);
    set_ghr(10'h000);
    probe(10'h055);
    check_eq("nalloc_n_hit",  32'(bus.Not_Taken_Arr_hit), 32'h1);
    check_eq("nalloc_n_pred", 32'(bus.Not_Taken_Arr_prediction), 32'h0);
    check_eq("nalloc_t_hit",  32'(bus.Taken_Arr_hit), 32'h0);
    finish_edge();

    // Lookup in the same cycle the pending write targets that index
    set_ghr(10'h000);
    cyc(10'h0, 1'b0, 1'b1, 1'b1, 10'h0A0, 10'h001, 1'b0);
    probe(10'h0A0);
`ifdef YAGS_UPDATE_BYPASS_EN
    check_eq("byp_same_hit", 32'(bus.Taken_Arr_hit), 32'h1);
`else
    check_eq("byp_same_hit", 32'(bus.Taken_Arr_hit), 32'h0);
`endif
    finish_edge();
    probe(10'h0A0);
    check_eq("byp_next_hit",  32'(bus.Taken_Arr_hit), 32'h1);
    check_eq("byp_next_pred", 32'(bus.Taken_Arr_prediction), 32'h1);
    finish_edge();

    // Randomized traffic: update bursts around a target history, then
    // restore that history and probe the pool with EX idle.
    for (int i = 0; i < 16; i++) pool[i] = 10'($urandom_range(0, 1023));
    for (int r = 0; r < 40; r++) begin
      if (r == 20) do_reset();
      tgt = 10'($urandom_range(0, 1023));
      for (int k = 0; k < 20; k++) begin
        cyc(pool[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
            pool[$urandom_range(0, 15)],
            ($urandom_range(0, 3) != 0) ? tgt : 10'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)));
      end
      set_ghr(tgt);
      for (int k = 0; k < 10; k++)
        cyc(pool[$urandom_range(0, 15)], 1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/yags_direction_cache.md
# yags_direction_cache

Tagged Taken/Not-Taken exception caches and global history register feeding the YAGS choice predictor in fetch. Each fetch cycle it looks up both caches with the fetch PC XOR the GHR and drives the per-cache hit and prediction bits that the choice-PHT stage muxes into the final prediction. It takes resolved-branch information from EX, shifts the GHR, and allocates or trains cache entries through a one-entry registered update stage.

## Interface
- GHR_size, 10: GHR width and cache index width; each cache has 2**GHR_size entries.
- PC_size, 10: width of PC inputs; must be >= GHR_size.
- TAG_size, 6: tag width, taken from PC[TAG_size-1:0]; must be <= PC_size.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC  in  PC_size  fetch-stage PC.
- branch  in  1  fetch instruction is a branch.
- branch_signal  in  1  EX instruction is a resolved conditional branch.
- actual_prediction  in  1  EX resolved outcome, 1 = taken.
- PC_from_branch_comp  in  PC_size  EX branch PC.
- GHR_EX  in  GHR_size  GHR value used when the EX branch was fetched.
- PHT_prediction_EX  in  1  choice-PHT bit the EX branch was fetched with.
- GHR  out  GHR_size  global history register.
- Taken_Arr_hit, Taken_Arr_prediction  out  1 each  taken-cache hit and counter MSB.
- Not_Taken_Arr_hit, Not_Taken_Arr_prediction  out  1 each  not-taken-cache hit and counter MSB.

## Operation
- Entry: valid bit, TAG_size tag, 2-bit counter (0 SNT, 1 WNT, 2 WT, 3 ST).
- Lookup (combinational): idx = PC[GHR_size-1:0] ^ GHR; hit = valid && tag == PC[TAG_size-1:0]; prediction = counter[1]. With branch = 0, all four lookup outputs are 0.
- GHR: on a rising edge with branch_signal = 1, GHR <= {GHR[GHR_size-2:0], actual_prediction}; otherwise it holds.
- Update capture: on a rising edge with branch_signal = 1, register upd_valid = 1, uidx = PC_from_branch_comp[GHR_size-1:0] ^ GHR_EX, utag, outcome, and cache select (NT cache if PHT_prediction_EX = 1, else T cache). Otherwise upd_valid <= 0.
- Update apply: on the next rising edge, if upd_valid, it reads the selected cache at uidx.
  - Tag hit: the counter saturating-increments if outcome = 1, otherwise saturating-decrements.
  - Miss with outcome != choice bit (choice wrong): it allocates valid = 1, tag = utag, counter = 2 if outcome is taken, 1 if not taken.
  - Miss with outcome == choice bit: no write.
- The unselected cache is never written. Only one write per cycle.
- Back-to-back EX branches: the capture register is overwritten every cycle. Every captured update is applied exactly once, on the following edge.

## Timing
- Lookup is zero-latency combinational from PC, branch, GHR and array state.
- GHR change is visible to fetch lookup one cycle after the EX branch edge.
- Array write lands two edges after EX presentation: capture, then apply.
- Reset: all valid bits 0, GHR = 0, upd_valid = 0. All outputs are 0 after reset. Reset mid-update discards the pending capture.
- Counter saturation: 3 + taken stays 3; 0 + not-taken stays 0.

## Configuration
- YAGS_UPDATE_BYPASS_EN defined: when upd_valid and the pending write targets the lookup index of a cache, that cache's lookup outputs reflect the post-write entry in the same cycle.
- YAGS_UPDATE_BYPASS_EN undefined: lookup always sees array contents only. A pending write becomes visible one cycle later.

## Test plan
- Reset, then branch = 1, PC = 0x0A5 -> all hit and prediction outputs 0, GHR = 0.
- EX branch_signal = 1, actual = 1 for three cycles -> GHR = 0x007 one cycle after the third edge.
- EX PC = 0x013, GHR_EX = 0x001, PHT_prediction_EX = 0, actual = 1 (miss) -> two edges later, fetch PC = 0x013 with GHR = 0x001 gives Taken_Arr_hit = 1, Taken_Arr_prediction = 1, Not_Taken_Arr_hit = 0.
- Same entry: two EX not-taken updates -> counter 2->1->0; prediction 0, hit stays 1; a third not-taken update leaves it at 0.
- EX miss with PHT_prediction_EX = 1, actual = 1 (choice correct) -> no allocation; Not_Taken_Arr_hit stays 0.
- Update applied in the same cycle as a fetch lookup to that index -> hit = 1 that cycle with YAGS_UPDATE_BYPASS_EN, hit = 0 that cycle and 1 the next without it.
